hyperram_arbiter: RTL and testbench

Arbitrates the single HyperRAM controller port between the camera frame writer (burst writes) and the CPU iomem window (single-word memory/register reads and writes). Sits between the capture FIFO drain logic, the SoC iomem decoder and the HyperRAM interface core. It sequences request pulses, burst continuation and read completion, and guarantees the CPU a slot under continuous capture traffic.

---
 rtl/hyperram_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_hyperram_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/hyperram_arbiter.sv
// hyperram_arbiter: shares one HyperRAM controller port between capture bursts and CPU iomem accesses; HYPERRAM_ARB_TIMEOUT_EN adds a CPU read timeout with sticky rd_timeout
module hyperram_arbiter #(
  parameter int BURST_MAX      = 8,
  parameter int CPU_STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cap_req,
  input  logic [31:0] cap_addr,
  input  logic [31:0] cap_d,
  input  logic        cap_valid,
  output logic        cap_take,
  input  logic        cpu_valid,
  input  logic        cpu_we,
  input  logic        cpu_reg,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ready,
  output logic [31:0] cpu_rdata,
  output logic        mem_rd_req,
  output logic        mem_wr_req,
  output logic        mem_or_reg,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wr_d,
  input  logic [31:0] mem_rd_d,
  input  logic        mem_rd_rdy,
  input  logic        mem_busy,
  input  logic        mem_burst_wr_rdy,
  output logic        grant_cap,
  output logic        grant_cpu
`ifdef HYPERRAM_ARB_TIMEOUT_EN
  ,
  output logic        rd_timeout
`endif
);
  typedef enum logic [2:0] {IDLE, CAP_FIRST, CAP_BURST, CPU_WR, CPU_RD, DRAIN} state_e;
  state_e state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [7:0] starve_q, starve_d, cyc_q, cyc_d;
  logic cap_take_q, cap_take_d, cpu_ready_q, cpu_ready_d, mem_rd_req_q, mem_rd_req_d;
  logic mem_wr_req_q, mem_wr_req_d, mem_or_reg_q, mem_or_reg_d;
  logic grant_cap_q, grant_cap_d, grant_cpu_q, grant_cpu_d;
  logic [31:0] cpu_rdata_q, cpu_rdata_d, mem_addr_q, mem_addr_d, mem_wr_d_q, mem_wr_d_d;
  logic arb_cpu, word_ok, burst_end, rd_done, tmo;
  assign arb_cpu   = cpu_valid && (!cap_req || starve_q == 8'(CPU_STARVE_MAX));
  assign word_ok   = mem_burst_wr_rdy && cap_valid && cnt_q < 6'(BURST_MAX);
  assign burst_end = cnt_q == 6'(BURST_MAX) || (mem_burst_wr_rdy && !cap_valid);
  assign rd_done   = cyc_q != 8'd0 && mem_rd_rdy;
`ifdef HYPERRAM_ARB_TIMEOUT_EN
  logic rd_timeout_q, rd_timeout_d;
  assign tmo        = cyc_q == 8'd255 && !mem_rd_rdy;
  assign rd_timeout = rd_timeout_q;
`else
  assign tmo = 1'b0;
`endif
  assign cap_take   = cap_take_q;
  assign cpu_ready  = cpu_ready_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign mem_rd_req = mem_rd_req_q;
  assign mem_wr_req = mem_wr_req_q;
  assign mem_or_reg = mem_or_reg_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wr_d   = mem_wr_d_q;
  assign grant_cap  = grant_cap_q;
  assign grant_cpu  = grant_cpu_q;
  // state and output registers; reset abandons any in-flight transaction
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      starve_q     <= '0;
      cyc_q        <= '0;
      cap_take_q   <= 1'b0;
      cpu_ready_q  <= 1'b0;
      mem_rd_req_q <= 1'b0;
      mem_wr_req_q <= 1'b0;
      mem_or_reg_q <= 1'b0;
      grant_cap_q  <= 1'b0;
      grant_cpu_q  <= 1'b0;
      cpu_rdata_q  <= '0;
      mem_addr_q   <= '0;
      mem_wr_d_q   <= '0;
`ifdef HYPERRAM_ARB_TIMEOUT_EN
      rd_timeout_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      starve_q     <= starve_d;
      cyc_q        <= cyc_d;
      cap_take_q   <= cap_take_d;
      cpu_ready_q  <= cpu_ready_d;
      mem_rd_req_q <= mem_rd_req_d;
      mem_wr_req_q <= mem_wr_req_d;
      mem_or_reg_q <= mem_or_reg_d;
      grant_cap_q  <= grant_cap_d;
      grant_cpu_q  <= grant_cpu_d;
      cpu_rdata_q  <= cpu_rdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_wr_d_q   <= mem_wr_d_d;
`ifdef HYPERRAM_ARB_TIMEOUT_EN
      rd_timeout_q <= rd_timeout_d;
`endif
    end
  end
  // next state: arbitration in IDLE, then each owner runs to DRAIN
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (!mem_busy && (cpu_valid || cap_req)) state_d = arb_cpu ? (cpu_we ? CPU_WR : CPU_RD) : CAP_FIRST;
      CAP_FIRST: if (cap_valid && !mem_busy) state_d = CAP_BURST;
      CAP_BURST: if (burst_end) state_d = DRAIN;
      CPU_WR:    if (cyc_q == 8'd2) state_d = DRAIN;
      CPU_RD:    if (rd_done || tmo) state_d = DRAIN;
      DRAIN:     if (!mem_busy) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end
  // outputs and counters; cyc counts cycles spent in the current state, saturating so it never re-reads as zero
  always_comb begin
    cap_take_d   = 1'b0;
    cpu_ready_d  = 1'b0;
    mem_rd_req_d = 1'b0;
    mem_wr_req_d = 1'b0;
    mem_or_reg_d = mem_or_reg_q;
    mem_addr_d   = mem_addr_q;
    mem_wr_d_d   = mem_wr_d_q;
    cpu_rdata_d  = cpu_rdata_q;
    cnt_d        = cnt_q;
    starve_d     = starve_q;
    cyc_d        = state_d != state_q ? 8'd0 : cyc_q == 8'hFF ? cyc_q : cyc_q + 8'd1;
    grant_cap_d  = state_d == IDLE ? 1'b0 : grant_cap_q | (state_q == IDLE && state_d == CAP_FIRST);
    grant_cpu_d  = state_d == IDLE ? 1'b0 : grant_cpu_q | (state_q == IDLE && (state_d == CPU_WR || state_d == CPU_RD));
`ifdef HYPERRAM_ARB_TIMEOUT_EN
    rd_timeout_d = rd_timeout_q | (state_q == CPU_RD && tmo);
`endif
    case (state_q)
      CAP_FIRST: if (cap_valid && !mem_busy) begin
        mem_wr_req_d = 1'b1;
        cap_take_d   = 1'b1;
        mem_addr_d   = cap_addr;
        mem_wr_d_d   = cap_d;
        mem_or_reg_d = 1'b0;
        cnt_d        = 6'd1;
      end
      CAP_BURST: begin
        if (word_ok) begin
          mem_wr_req_d = 1'b1;
          cap_take_d   = 1'b1;
          mem_wr_d_d   = cap_d;
          cnt_d        = cnt_q + 6'd1;
        end
        if (burst_end) starve_d = starve_q == 8'(CPU_STARVE_MAX) ? starve_q : starve_q + 8'd1;
      end
      CPU_WR: begin
        if (cyc_q == 8'd0) begin
          mem_wr_req_d = 1'b1;
          mem_addr_d   = cpu_addr;
          mem_wr_d_d   = cpu_wdata;
          mem_or_reg_d = cpu_reg;
        end
        if (cyc_q == 8'd2) begin
          cpu_ready_d = cpu_valid;
          starve_d    = '0;
        end
      end
      CPU_RD: begin
        if (cyc_q == 8'd0) begin
          mem_rd_req_d = 1'b1;
          mem_addr_d   = cpu_addr;
          mem_or_reg_d = cpu_reg;
        end
        if (rd_done || tmo) begin
          cpu_rdata_d = rd_done ? mem_rd_d : 32'hDEADBEEF;
          cpu_ready_d = cpu_valid;
          starve_d    = '0;
        end
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_hyperram_arbiter.sv
// tb_hyperram_arbiter: scoreboard bench with a controller model, a capture FIFO model and a CPU driver
module tb_hyperram_arbiter;
  localparam int BM = 8;
  logic clk = 1'b0, resetn = 1'b0;
  logic cpu_we = 1'b0, cpu_reg = 1'b0, mem_rd_rdy = 1'b0, mem_busy = 1'b0, mem_burst_wr_rdy = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0, mem_rd_d = '0, cap_base = '0;
  logic cap_req, cap_valid, cpu_valid, cap_take, cpu_ready, mem_rd_req, mem_wr_req, mem_or_reg, grant_cap, grant_cpu;
  logic [31:0] cap_addr, cap_d, cpu_rdata, mem_addr, mem_wr_d;
  logic cpu_tog = 1'b0, cpu_ack = 1'b0;
`ifdef HYPERRAM_ARB_TIMEOUT_EN
  logic rd_timeout;
`endif
  typedef struct packed {logic rd; logic or_reg; logic chk_data; logic cpu; logic [31:0] addr; logic [31:0] data;} mreq_t;
  typedef struct packed {logic chk_data; logic from_rdy; logic [31:0] data; logic [8:0] lat;} rsp_t;
  mreq_t mq[$];
  rsp_t rq[$];
  mreq_t e;
  rsp_t r;
  int n_vec = 0, n_miss = 0;
  int cyc = 0, busy_left = 0, rd_left = 0, ph = 0, rd_lat = 0, takes = 0, last_cpu_req = 0, last_rdy = 0;
  int cap_idx = 0, cap_off = 0, cap_end = 0;
  logic [31:0] rd_val = '0;

  always #5 clk = ~clk;

  assign cpu_valid = cpu_tog != cpu_ack;
  assign cap_valid = cap_idx < cap_end;
  assign cap_req   = cap_valid;
  assign cap_d     = 32'hC0DE0000 + 32'(cap_idx - cap_off);
  assign cap_addr  = cap_base + 32'(cap_idx - cap_off);

  hyperram_arbiter #(.BURST_MAX(BM), .CPU_STARVE_MAX(4)) dut (
    .clk(clk), .resetn(resetn),
    .cap_req(cap_req), .cap_addr(cap_addr), .cap_d(cap_d), .cap_valid(cap_valid), .cap_take(cap_take),
    .cpu_valid(cpu_valid), .cpu_we(cpu_we), .cpu_reg(cpu_reg), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_or_reg(mem_or_reg), .mem_addr(mem_addr),
    .mem_wr_d(mem_wr_d), .mem_rd_d(mem_rd_d), .mem_rd_rdy(mem_rd_rdy), .mem_busy(mem_busy),
    .mem_burst_wr_rdy(mem_burst_wr_rdy), .grant_cap(grant_cap), .grant_cpu(grant_cpu)
`ifdef HYPERRAM_ARB_TIMEOUT_EN
    , .rd_timeout(rd_timeout)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // monitor, controller model and capture FIFO, all sampled away from the active edge
  always @(negedge clk) begin
    cyc++;
    if (resetn) begin
      if (mem_wr_req || mem_rd_req) begin
        if (mq.size() == 0) chk("unexpected_req", 32'(mem_addr), 32'hFFFFFFFF);
        else begin
          e = mq.pop_front();
          chk("req_kind", 32'(mem_rd_req), 32'(e.rd));
          chk("req_addr", mem_addr, e.addr);
          if (e.chk_data) chk("req_data", mem_wr_d, e.data);
          chk("req_space", 32'(mem_or_reg), 32'(e.or_reg));
          chk("req_grant", 32'(e.cpu ? grant_cpu : grant_cap), 32'd1);
          chk("req_take", 32'(cap_take), 32'(!e.cpu));
          if (e.cpu) last_cpu_req = cyc;
        end
      end
      if (cpu_ready) begin
        if (rq.size() == 0) chk("unexpected_ready", 32'(cpu_ready), 32'd0);
        else begin
          r = rq.pop_front();
          if (r.chk_data) chk("rdata", cpu_rdata, r.data);
          chk("ready_lat", 32'(cyc - (r.from_rdy ? last_rdy : last_cpu_req)), 32'(r.lat));
        end
        cpu_ack = ~cpu_ack;
      end
      if (cap_take) begin
        takes++;
        cap_idx++;
      end
      if (mem_wr_req || mem_rd_req) busy_left = 6;
      else if (busy_left > 0) busy_left--;
      mem_busy = busy_left > 0;
      ph = (ph + 1) % 4;
      mem_burst_wr_rdy = ph == 0;
      mem_rd_rdy = 1'b0;
      if (mem_rd_req) rd_left = rd_lat;
      else if (rd_left > 0) begin
        rd_left--;
        if (rd_left == 0) begin
          mem_rd_rdy = 1'b1;
          mem_rd_d = rd_val;
          last_rdy = cyc;
        end
      end
    end else begin
      busy_left = 0;
      rd_left = 0;
      mem_busy = 1'b0;
      mem_rd_rdy = 1'b0;
      mem_burst_wr_rdy = 1'b0;
    end
  end

  task automatic push_cap(input logic [31:0] base, input int i0, input int i1);
    for (int i = i0; i < i1; i++)
      mq.push_back('{rd: 1'b0, or_reg: 1'b0, chk_data: 1'b1, cpu: 1'b0, addr: base + 32'((i / BM) * BM), data: 32'hC0DE0000 + 32'(i)});
  endtask

  task automatic start_cap(input logic [31:0] base, input int n);
    cap_base = base;
    cap_off = cap_idx;
    cap_end = cap_idx + n;
  endtask

  task automatic cpu_issue(input logic we, input logic rg, input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rv, input int lat);
    mq.push_back('{rd: !we, or_reg: rg, chk_data: we, cpu: 1'b1, addr: a, data: wd});
    rq.push_back('{chk_data: !we, from_rdy: !we && lat != 0, data: lat != 0 ? rv : 32'hDEADBEEF, lat: we ? 9'd2 : lat != 0 ? 9'd1 : 9'd255});
    rd_val = rv;
    rd_lat = lat;
    cpu_we = we;
    cpu_reg = rg;
    cpu_addr = a;
    cpu_wdata = wd;
    cpu_tog = ~cpu_tog;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while ((mq.size() != 0 || rq.size() != 0 || cpu_valid || cap_req || grant_cap || grant_cpu || mem_busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, 32'(n < 2000), 32'd1);
    @(posedge clk);
    #1;
  endtask

  int n, t0;
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_pulses", 32'({cap_take, cpu_ready, mem_rd_req, mem_wr_req, mem_or_reg, grant_cap, grant_cpu}), 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wr_d, 32'd0);
`ifdef HYPERRAM_ARB_TIMEOUT_EN
    chk("rst_tmo", 32'(rd_timeout), 32'd0);
`endif
    @(posedge clk);
    #1 resetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cpu_issue(1'b1, 1'b0, 32'h10, 32'hA5A5A5A5, 32'd0, 0);
    wait_done("cpu_wr");
    cpu_issue(1'b0, 1'b1, 32'h4, 32'd0, 32'h0C81, 20);
    wait_done("cpu_rd");
    t0 = takes;
    push_cap(32'h1000, 0, 8);
    start_cap(32'h1000, 8);
    wait_done("cap8");
    chk("cap8_takes", 32'(takes - t0), 32'd8);
    t0 = takes;
    push_cap(32'h2000, 0, 3);
    start_cap(32'h2000, 3);
    wait_done("cap3");
    chk("cap3_takes", 32'(takes - t0), 32'd3);
    cpu_issue(1'b1, 1'b1, 32'h20, 32'h12345678, 32'd0, 0);
    wait_done("cpu_wr_reg");
    push_cap(32'h3000, 0, 32);
    cpu_issue(1'b0, 1'b0, 32'h40, 32'd0, 32'hBEEF0001, 20);
    push_cap(32'h3000, 32, 40);
    start_cap(32'h3000, 40);
    wait_done("starve");
    push_cap(32'h4000, 0, 8);
    cpu_issue(1'b0, 1'b0, 32'h44, 32'd0, 32'hBEEF0002, 5);
    start_cap(32'h4000, 8);
    wait_done("starve_clr");
`ifdef HYPERRAM_ARB_TIMEOUT_EN
    cpu_issue(1'b0, 1'b0, 32'h50, 32'd0, 32'd0, 0);
    wait_done("rd_tmo");
    chk("rd_timeout", 32'(rd_timeout), 32'd1);
`endif
    t0 = takes;
    push_cap(32'h5000, 0, 8);
    start_cap(32'h5000, 8);
    n = 0;
    while (takes - t0 < 3 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("mid_burst_reach", 32'(n < 500), 32'd1);
    chk("mid_burst_grant", 32'(grant_cap), 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_pulses", 32'({cap_take, cpu_ready, mem_rd_req, mem_wr_req, mem_or_reg, grant_cap, grant_cpu}), 32'd0);
    chk("async_rst_addr", mem_addr, 32'd0);
    chk("async_rst_wdata", mem_wr_d, 32'd0);
    mq.delete();
    cap_end = cap_idx;
    @(posedge clk);
    #1 resetn = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    wait_done("post_rst");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
